vga_timing_gen: RTL



---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_sync_pipe.sv | 42 ++++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator.
// Holds the default 640x480@60 timing constants, a compile-time clog2,
// and helpers that derive line/frame totals from the porch/sync widths.
package vga_timing_pkg;

    // Default 640x480@60 timing (25 MHz pixel rate from a 50 MHz clock).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Total count of one axis: active + front porch + sync + back porch.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Clock cycles in one full frame.
    function automatic int frame_cycles(input int h_total, input int v_total,
                                        input int clk_div);
        return h_total * v_total * clk_div;
    endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// Delay line for the blank/sync decodes so they line up with a pipelined
// pixel memory addressed by posx/posy.
// Ports:
//   Clock  - system clock
//   reset  - synchronous, active-high; loads RST_VAL into every stage
//   ce     - advance the line by one stage (pixel tick)
//   d      - undelayed bits
//   q      - bits delayed by DEPTH ticks (d itself when DEPTH is 0)
module vga_sync_pipe #(
    parameter int             DEPTH   = 1,
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         Clock,
    input  logic         reset,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused;
            assign unused = ^{Clock, reset, ce};
            assign q      = d;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge Clock) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else if (ce) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator.
// Ports:
//   Clock       - system clock
//   reset       - synchronous, active-high reset (wins over enable)
//   enable      - run when high; when low all state holds and pix_ce is 0
//   pix_ce      - one-clock pixel tick, high in the cycle the divider wraps
//   posx, posy  - active-area coordinates >> SCALE_SHIFT (0 outside active)
//   blank       - high outside the active area, delayed PIPE_DEPTH ticks
//   Hsinc/Vsinc - sync outputs at HS_POL/VS_POL, delayed PIPE_DEPTH ticks
//   line_start  - pulse in the cycle the outputs first show h = 0
//   frame_start - pulse in the cycle the outputs first show (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int PIPE_DEPTH  = 1,
    parameter int SCALE_SHIFT = 0,
    localparam int XW = clog2(H_ACTIVE),
    localparam int YW = clog2(V_ACTIVE)
) (
    input  logic          Clock,
    input  logic          reset,
    input  logic          enable,
    output logic          pix_ce,
    output logic [XW-1:0] posx,
    output logic [YW-1:0] posy,
    output logic          blank,
    output logic          Hsinc,
    output logic          Vsinc,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);
    localparam int DW      = cnt_w(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pipe stages hold {blank, Vsinc, Hsinc}; they come out of reset blanked
    // with both syncs inactive.
    localparam logic [2:0] PIPE_RST = {1'b1, ~VS_POL, ~HS_POL};

    logic [DW-1:0] div, div_nxt;
    logic [HW-1:0] h, h_nxt;
    logic [VW-1:0] v, v_nxt;
    logic          tick;
    logic          blank_raw, hs_raw, vs_raw;

    // A tick happens at the edge closing a visible pix_ce cycle, so every
    // count step is announced by pix_ce. After a pause the divider parks on
    // its last value until pix_ce has been shown again, which keeps the
    // resumed count exact.
    assign tick = enable & pix_ce;

    always_comb begin
        div_nxt = div;
        h_nxt   = h;
        v_nxt   = v;
        if (tick) begin
            div_nxt = '0;
            if (h == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h_nxt = h + 1'b1;
            end
        end else if (div != DIV_LAST) begin
            div_nxt = div + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            pix_ce      <= 1'b0;
            posx        <= '0;
            posy        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            blank_raw   <= 1'b0;
            hs_raw      <= ~HS_POL;
            vs_raw      <= ~VS_POL;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (enable) begin
                div    <= div_nxt;
                pix_ce <= (div_nxt == DIV_LAST);
            end else begin
                pix_ce <= 1'b0;
            end
            if (tick) begin
                h           <= h_nxt;
                v           <= v_nxt;
                posx        <= (h_nxt < H_ACT) ? XW'(h_nxt >> SCALE_SHIFT) : '0;
                posy        <= (v_nxt < V_ACT) ? YW'(v_nxt >> SCALE_SHIFT) : '0;
                blank_raw   <= (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
                hs_raw      <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HS_POL : ~HS_POL;
                vs_raw      <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VS_POL : ~VS_POL;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

    vga_sync_pipe #(
        .DEPTH   (PIPE_DEPTH),
        .W       (3),
        .RST_VAL (PIPE_RST)
    ) u_sync_pipe (
        .Clock (Clock),
        .reset (reset),
        .ce    (tick),
        .d     ({blank_raw, vs_raw, hs_raw}),
        .q     ({blank, Vsinc, Hsinc})
    );

endmodule
